// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the multi-port register file
package regfile_pkg;
  localparam int RF_XLEN = 32;
  typedef enum logic {CLEAR, READY} rf_state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set/clear/flush and NRD lookups
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic                   clr_en,
  input  logic [AW-1:0]          clr_addr,
  input  logic [NRD-1:0][AW-1:0] ra,
  output logic [NRD-1:0]         hit
);
  logic [NREG-1:0] busy, busy_d;
  // clear applied first so a same-address set wins; register 0 is never pending
  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
  end
  // pending bits drop on reset and on the cycle a clear sweep starts
  always_ff @(posedge clk) begin
    if (reset || flush) busy <= '0;
    else busy <= busy_d;
  end
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign hit[g] = busy[ra[g]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with zeroing sweep, write-first bypass and scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic [NRD-1:0][AW-1:0]   ra,
  output logic [NRD-1:0][XLEN-1:0] rd,
  output logic [NRD-1:0]           rbusy,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [XLEN-1:0]          wd,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr
);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  rf_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [XLEN-1:0] mem [NREG];
  logic wr_ok, flush, mem_we;
  logic [AW-1:0] mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic [NRD-1:0] hit;
  assign ready = state_q == READY;
  assign wr_ok = ready & ~clear_req;
  assign flush = ready & clear_req;
  assign mem_we = ~ready | (wr_ok & we & (wa != '0));
  assign mem_wa = ready ? wa : idx_q;
  assign mem_wd = ready ? wd : '0;
  // sweep advances one register per cycle; idx parks at 0 while ready so a new sweep starts there
  always_comb begin
    state_d = (state_q == CLEAR) ? ((idx_q == LAST) ? READY : CLEAR) : (clear_req ? CLEAR : READY);
    idx_d = (state_q == CLEAR) ? idx_q + 1'b1 : '0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  // single write port shared by the sweep and normal writes
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_wa] <= mem_wd;
  end
  regfile_scoreboard #(.NREG(NREG), .NRD(NRD)) u_sb (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .set_en(wr_ok & alloc_en),
    .set_addr(alloc_addr),
    .clr_en(wr_ok & we),
    .clr_addr(wa),
    .ra(ra),
    .hit(hit)
  );
  for (genvar g = 0; g < NRD; g++) begin : g_rp
    assign rd[g] = (!ready || ra[g] == '0) ? '0 : (we && wa == ra[g]) ? wd : mem[ra[g]];
    assign rbusy[g] = ready & hit[g];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized check of regfile_mp against a behavioural model plus directed pins
module tb_regfile_mp;
  logic clk = 0, reset = 1, clear_req = 0, we = 0, alloc_en = 0;
  logic [4:0] wa = 0, alloc_addr = 0;
  logic [31:0] wd = 0;
  logic [1:0][4:0] ra = '0;
  logic [1:0][31:0] rd;
  logic [1:0] rbusy;
  logic ready;
  int n_vec = 0, n_err = 0;
  bit chk_en = 0;
  logic [31:0] m_mem [32];
  bit m_busy [32];
  bit m_ready = 0;
  int m_cnt = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .ra(ra), .rd(rd), .rbusy(rbusy), .we(we), .wa(wa), .wd(wd),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // model of one rising edge, written from the register-file rules
  task automatic model_tick();
    if (reset) begin
      m_ready = 0;
      m_cnt = 0;
      foreach (m_busy[k]) m_busy[k] = 0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == 32) m_ready = 1;
    end else if (clear_req) begin
      m_ready = 0;
      m_cnt = 0;
      foreach (m_busy[k]) m_busy[k] = 0;
    end else begin
      if (we && wa != 0) begin
        m_mem[wa] = wd;
        m_busy[wa] = 0;
      end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1;
    end
  endtask

  function automatic logic [31:0] exp_rd(int i);
    if (!m_ready || ra[i] == 0) return 0;
    if (we && wa == ra[i]) return wd;
    return m_mem[ra[i]];
  endfunction

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  function automatic logic [4:0] pick();
    return $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  // counts cycles with ready low from now until it rises (bounded)
  task automatic count_low(output int n);
    n = 0;
    #2;
    while (!ready && n < 200) begin
      n++;
      step();
      #2;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(m_ready));
      for (int i = 0; i < 2; i++) begin
        chk("rd", rd[i], exp_rd(i));
        chk("rbusy", 32'(rbusy[i]), 32'(m_ready && m_busy[ra[i]]));
      end
    end
  end

  initial begin
    int n;
    for (int c = 0; c < 3; c++) step();
    chk_en = 1;
    #2;
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_rd", rd[0], 32'h0);
    reset = 0;
    count_low(n);
    chk("init_low_cycles", n, 32);
    chk("init_ready", 32'(ready), 32'h1);
    ra[0] = 5; ra[1] = 9;
    #1;
    chk("swept_rd", rd[1], 32'h0);
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    #1;
    chk("bypass_x5", rd[0], 32'hDEADBEEF);
    step();
    we = 0;
    #2;
    chk("stored_x5", rd[0], 32'hDEADBEEF);
    we = 1; wa = 0; wd = 32'h12345678; ra[0] = 0; ra[1] = 0;
    #1;
    chk("x0_bypass", rd[0], 32'h0);
    step();
    we = 0; alloc_en = 1; alloc_addr = 0;
    step();
    alloc_en = 0;
    #2;
    chk("x0_rd", rd[1], 32'h0);
    chk("x0_busy", 32'(rbusy[0]), 32'h0);
    alloc_en = 1; alloc_addr = 7; ra[1] = 7;
    step();
    alloc_en = 0;
    #2;
    chk("x7_alloc", 32'(rbusy[1]), 32'h1);
    step();
    alloc_en = 1; we = 1; wa = 7; wd = 32'hA5A5_5A5A;
    step();
    alloc_en = 0; we = 0;
    #2;
    chk("x7_set_prio", 32'(rbusy[1]), 32'h1);
    chk("x7_data", rd[1], 32'hA5A5_5A5A);
    we = 1; wd = 32'h0000_0077;
    step();
    we = 0;
    #2;
    chk("x7_write_clr", 32'(rbusy[1]), 32'h0);
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 599) == 0;
      clear_req = $urandom_range(0, 149) == 0;
      we = $urandom_range(0, 1);
      wa = pick();
      wd = $urandom;
      alloc_en = $urandom_range(0, 2) == 0;
      alloc_addr = pick();
      ra[0] = pick();
      ra[1] = $urandom_range(0, 3) == 0 ? ra[0] : pick();
      step();
    end
    reset = 0; clear_req = 0; we = 0; alloc_en = 0;
    count_low(n);
    chk("rand_ready", 32'(ready), 32'h1);
    we = 1; wa = 3; wd = 32'h2; alloc_en = 1; alloc_addr = 4;
    step();
    we = 0; alloc_en = 0; clear_req = 1;
    step();
    clear_req = 0; we = 1; wa = 9; wd = 32'hFFFF_0000; alloc_en = 1; alloc_addr = 9;
    count_low(n);
    we = 0; alloc_en = 0;
    chk("clr_low_cycles", n, 32);
    ra[0] = 3; ra[1] = 9;
    #1;
    chk("clr_x3", rd[0], 32'h0);
    chk("clr_lost_write", rd[1], 32'h0);
    chk("clr_busy9", 32'(rbusy[1]), 32'h0);
    ra[1] = 4;
    #1;
    chk("clr_busy4", 32'(rbusy[1]), 32'h0);
    clear_req = 1;
    step();
    clear_req = 0;
    for (int c = 0; c < 10; c++) step();
    reset = 1;
    step();
    reset = 0;
    count_low(n);
    chk("restart_low_cycles", n, 32);
    step();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
